iadc_bitstream_gen: RTL

Digital first-order incremental delta-sigma modulator model: the bitstream source that feeds the decimator. On each `start` it latches a 12-bit unsigned input code and emits exactly 2^OSR_LOG2 single-bit samples. The integrator is reset at the start of every conversion. Used as the stimulus front end in the decimator verification path and as a drop-in digital stand-in for the analog modulator.

---
 rtl/iadc_bitstream_gen.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/iadc_bitstream_gen.sv
// ----------------------------------------------------------------------------
// iadc_bitstream_gen
//
// First-order incremental delta-sigma modulator modelled in the digital
// domain. An accepted start latches an unsigned input code and clears the
// integrator. The block then emits exactly 2**OSR_LOG2 single-bit samples,
// one per clock.
//
// The modulator is built as a phase accumulator. On every sample the latched
// code is added to the integrator. The carry out of the top integrator bit is
// the output bit, and the remainder stays in the integrator. After k samples
// the integrator therefore holds (k*u) mod 2**DATA_WIDTH, and the number of
// ones emitted so far is floor(k*u / 2**DATA_WIDTH).
//
// A start that arrives on the final sample of a conversion is taken as a
// back-to-back request. The next conversion then follows with no idle gap,
// and bit_valid stays high across the boundary.
// ----------------------------------------------------------------------------
module iadc_bitstream_gen #(
  parameter int DATA_WIDTH = 12,
  parameter int OSR_LOG2   = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  start,
  output logic                  busy,
  output logic                  bit_out,
  output logic                  bit_valid,
  output logic                  bit_first,
  output logic                  bit_last
);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_CONVERT = 1'b1
  } state_t;

  // The last sample index is N-1. With a full-width counter that is all ones.
  localparam logic [OSR_LOG2-1:0] CNT_LAST = '1;

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  state_t                state_q,     state_d;
  logic [DATA_WIDTH-1:0] u_q,         u_d;
  logic [DATA_WIDTH-1:0] acc_q,       acc_d;
  logic [OSR_LOG2-1:0]   cnt_q,       cnt_d;
  logic                  busy_q,      busy_d;
  logic                  bit_out_q,   bit_out_d;
  logic                  bit_valid_q, bit_valid_d;
  logic                  bit_first_q, bit_first_d;
  logic                  bit_last_q,  bit_last_d;

  // The integrator sum is one bit wider than the code. Its top bit is the
  // quantizer decision.
  logic [DATA_WIDTH:0]   sum;
  logic                  cnt_at_last;

  assign sum         = {1'b0, acc_q} + {1'b0, u_q};
  assign cnt_at_last = (cnt_q == CNT_LAST);

  // Next-state and next-output logic for the conversion sequencer
  always_comb begin
    // NOTE: every signal gets a default before the case statement, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_d     = state_q;
    u_d         = u_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    busy_d      = 1'b0;
    bit_out_d   = 1'b0;
    bit_valid_d = 1'b0;
    bit_first_d = 1'b0;
    bit_last_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // data_in is looked at only when a start is accepted.
        if (start) begin
          u_d     = data_in;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_CONVERT;
        end
      end

      S_CONVERT: begin
        // busy stays high through the cycle that presents bit_last. It drops
        // one edge later, unless a back-to-back start keeps it up.
        busy_d      = 1'b1;
        bit_out_d   = sum[DATA_WIDTH];
        bit_valid_d = 1'b1;
        bit_first_d = (cnt_q == '0);
        bit_last_d  = cnt_at_last;
        acc_d       = sum[DATA_WIDTH-1:0];
        cnt_d       = cnt_q + OSR_LOG2'(1);

        // A start at any other cycle of the conversion is ignored.
        if (cnt_at_last) begin
          if (start) begin
            u_d   = data_in;
            acc_d = '0;
            cnt_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Register all state and outputs; the reset is synchronous and active-low
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values from before the edge, whatever order they appear in.
    if (!rst_n) begin
      state_q     <= S_IDLE;
      u_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      bit_first_q <= 1'b0;
      bit_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      u_q         <= u_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      bit_first_q <= bit_first_d;
      bit_last_q  <= bit_last_d;
    end
  end

  assign busy      = busy_q;
  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign bit_first = bit_first_q;
  assign bit_last  = bit_last_q;

endmodule
